regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Hazard scoreboard for the pipelined RISC-V core's 32×32 register file. Decode presents each instruction's source and destination registers. The block tracks outstanding (issued, not yet written back) writes per architectural register, and grants issue only when no source operand is pending. The writeback stage retires entries. A flush from the branch/exception path clears all tracking.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; x0 is never tracked.
- AW, 5, register index width.
- CW, 2, per-register outstanding-write counter width; at most 2^CW−1 writes in flight per register.
- TW, 4, width of the total in-flight counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  AW  source register 1.
- issue_rs2  in  AW  source register 2.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_wen  in  1  instruction writes rd.
- issue_rd  in  AW  destination register.
- issue_ready  out  1  combinational; no hazard, so the instruction may issue this cycle.
- wb_valid  in  1  writeback writes wb_rd this cycle (same strobe as the register-file WriteEnable).
- wb_rd  in  AW  register being written back.
- flush  in  1  discard all in-flight tracking.
- busy_mask  out  NREGS  registered; bit r is 1 when register r has count > 0.
- inflight  out  TW  registered; total outstanding writes, saturating.
- err  out  1  registered, sticky; protocol violation detected.

## Operation
- State: one CW-bit counter per register 1..NREGS−1, the inflight counter, and the err flag.
- Hazard on source s (s = rs1 or rs2) exists when all of these hold:
  - use_s = 1 and s ≠ 0;
  - count[s] > 0;
  - NOT (wb_valid and wb_rd = s and count[s] = 1). This exception holds because writeback data is visible to the register-file read in the same cycle.
- Structural hazard: issue_wen = 1, issue_rd ≠ 0 and count[rd] = 2^CW−1. Inflight saturation also blocks any issue with issue_wen = 1.
- issue_ready = !flush and no source hazard and no structural hazard. It is independent of issue_valid.
- Accept: issue_valid & issue_ready. If issue_wen = 1 and issue_rd ≠ 0, count[rd] increments.
- Retire: wb_valid with wb_rd ≠ 0 decrements count[wb_rd].
- Accept and retire on the same register in one cycle leave the count unchanged.
- Retire with count[wb_rd] = 0: count stays 0 and err is set.
- Flush: all counts and inflight go to 0 next edge. flush has priority over a simultaneous accept and retire. Retires in a flush cycle are ignored, with no err check.
- inflight tracks (accepts with rd ≠ 0) − (valid retires) and clamps at 0 and 2^TW−1.
- Writes to x0 (issue or wb) never change state and never set err.
- err clears only on rst.

## Timing
- Reset: all counts 0; busy_mask = 0; inflight = 0; err = 0. issue_ready is 1 during reset (no hazards), but accepts in a reset cycle are discarded.
- issue_ready settles combinationally in the same cycle from the current state plus wb_* and flush.
- busy_mask, inflight and err update one cycle after the causing accept, retire or flush.
- Reset asserted mid-operation overrides flush, accept and retire in that cycle.

## Structure
- Shared package `rv_pkg`: AW, NREGS, the register-index typedef, and the X0 constant. These are shared with the register file and hazard/forward logic.
- One natural sub-module: `sb_counter`, a per-register CW-bit up/down counter with inc, dec and clr inputs and an underflow flag. It is instantiated NREGS−1 times via generate.
- Top level holds the hazard compare, the inflight counter and the err latch.

## Test plan
- Reset, then issue rd=x5 (wen) → next cycle busy_mask[5]=1 and inflight=1. A following instruction with rs1=x5 gets issue_ready=0 until wb_rd=5. In the wb cycle issue_ready=1; next cycle busy_mask[5]=0.
- Issue three writes to x7 back-to-back → count[7]=3. A fourth write to x7 gets issue_ready=0. A wb to x7 in the same cycle still gives 0; the following cycle it is allowed.
- Accept a write to x3 and wb to x3 in the same cycle with count[3]=1 → count stays 1 and busy_mask[3] stays 1.
- Set busy on x1, x2, x9, then assert flush together with issue_valid (rd=x4) → issue_ready=0, busy_mask=0 and inflight=0 next cycle, and x4 is not tracked.
- wb_rd=x12 with count 0 → err=1 next cycle and stays 1. wb_rd=x0 alone leaves err=0. Issuing with rs1=x0 and rd=x0 gives issue_ready=1 and no state change.
- Assert rst while busy_mask≠0 and wb_valid=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file definitions for the RISC-V core.
// The register file, the hazard/forward logic and the scoreboard all use
// these, so they always agree on the register count and index width.
//   AW        register index width
//   NREGS     number of architectural registers
//   reg_idx_t register index type
//   X0        the hard-wired zero register
package rv_pkg;

  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundles the decode-issue, writeback, flush and
// status signals of the register hazard scoreboard.
//   master : decode/writeback side, drives issue_*, wb_*, flush
//   slave  : scoreboard side, drives issue_ready, busy_mask, inflight, err
interface regfile_scoreboard_if
  import rv_pkg::*;
#(
  parameter int TW = 4
);

  logic            issue_valid;
  reg_idx_t        issue_rs1;
  reg_idx_t        issue_rs2;
  logic            issue_use_rs1;
  logic            issue_use_rs2;
  logic            issue_wen;
  reg_idx_t        issue_rd;
  logic            issue_ready;
  logic            wb_valid;
  reg_idx_t        wb_rd;
  logic            flush;
  logic [NREGS-1:0] busy_mask;
  logic [TW-1:0]   inflight;
  logic            err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_wen, issue_rd, wb_valid, wb_rd, flush,
    input  issue_ready, busy_mask, inflight, err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_wen, issue_rd, wb_valid, wb_rd, flush,
    output issue_ready, busy_mask, inflight, err
  );

endinterface

// File: rtl/sb_counter.sv
// sb_counter: outstanding-write counter for one architectural register.
//   clk, rst   clock and synchronous active-high reset
//   inc        one more write to this register was issued
//   dec        one write to this register was retired
//   clr        drop all tracking (pipeline flush)
//   count      current number of outstanding writes
//   underflow  a retire arrived while nothing was outstanding
// The issue side never increments a saturated counter (it stalls instead),
// so only the bottom of the range needs guarding here.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          underflow
);

  // Simultaneous inc and dec cancel; a decrement at zero holds at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign underflow = dec && (count == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: RAW/structural hazard scoreboard for the 32x32
// register file. Tracks issued-but-not-written-back writes per register
// and only lets an instruction issue when none of its sources is pending.
//   clk, rst  clock and synchronous active-high reset
//   sb        slave side of regfile_scoreboard_if:
//             issue_* from decode, issue_ready back (combinational),
//             wb_valid/wb_rd from writeback, flush from branch/exception,
//             busy_mask/inflight/err status (registered)
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = rv_pkg::NREGS,
  parameter int CW    = 2,
  parameter int TW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  sb
);

  logic [NREGS-1:0][CW-1:0] count;
  logic [NREGS-1:0]         uflow;
  logic [NREGS-1:0]         busy;
  logic [TW-1:0]            inflight_q;
  logic                     err_q;
  logic                     haz_rs1;
  logic                     haz_rs2;
  logic                     haz_struct;
  logic                     ready;
  logic                     inc_track;
  logic                     retire;
  logic                     dec_valid;

  // x0 is hard-wired zero and never tracked.
  assign count[0] = '0;
  assign uflow[0] = 1'b0;

  // A pending source is not a hazard if its last outstanding write is
  // being written back right now: the register-file read sees that data
  // in the same cycle. Saturated per-register or total counters stall any
  // writing instruction so neither counter can wrap.
  always_comb begin
    haz_rs1 = sb.issue_use_rs1 && (sb.issue_rs1 != X0)
              && (count[sb.issue_rs1] != '0)
              && !(sb.wb_valid && (sb.wb_rd == sb.issue_rs1)
                   && (count[sb.issue_rs1] == CW'(1)));
    haz_rs2 = sb.issue_use_rs2 && (sb.issue_rs2 != X0)
              && (count[sb.issue_rs2] != '0)
              && !(sb.wb_valid && (sb.wb_rd == sb.issue_rs2)
                   && (count[sb.issue_rs2] == CW'(1)));
    haz_struct = sb.issue_wen
                 && (((sb.issue_rd != X0) && (count[sb.issue_rd] == '1))
                     || (inflight_q == '1));
    ready = !sb.flush && !haz_rs1 && !haz_rs2 && !haz_struct;
  end

  assign sb.issue_ready = ready;

  // Flush discards both new accepts (through ready) and retires.
  assign inc_track = sb.issue_valid && ready && sb.issue_wen && (sb.issue_rd != X0);
  assign retire    = sb.wb_valid && (sb.wb_rd != X0) && !sb.flush;
  assign dec_valid = retire && (count[sb.wb_rd] != '0);

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_track && (sb.issue_rd == reg_idx_t'(r))),
      .dec       (retire && (sb.wb_rd == reg_idx_t'(r))),
      .clr       (sb.flush),
      .count     (count[r]),
      .underflow (uflow[r])
    );
  end

  // Busy bits come straight from the counter flops, so they lag the
  // causing event by exactly one edge.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy[r] = (count[r] != '0);
    end
  end

  assign sb.busy_mask = busy;

  // Total in-flight writes; only retires that matched a real outstanding
  // write count, and the value clamps at both ends.
  always_ff @(posedge clk) begin
    if (rst || sb.flush) begin
      inflight_q <= '0;
    end else if (inc_track && !dec_valid && (inflight_q != '1)) begin
      inflight_q <= inflight_q + TW'(1);
    end else if (dec_valid && !inc_track && (inflight_q != '0)) begin
      inflight_q <= inflight_q - TW'(1);
    end
  end

  // Sticky protocol error: a writeback to a register with nothing pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|uflow) begin
      err_q <= 1'b1;
    end
  end

  assign sb.inflight = inflight_q;
  assign sb.err      = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard.
// Inputs change 1 time unit after each rising edge; issue_ready is sampled
// once they settle, registered outputs 1 unit after the following edge.
module tb_regfile_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_scoreboard_if sbIf ();

  regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle worth of inputs and let combinational logic settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic w,
                               input logic [4:0] rd, input logic wbv, input logic [4:0] wbrd,
                               input logic fl);
    sbIf.issue_valid   = v;
    sbIf.issue_rs1     = rs1;
    sbIf.issue_use_rs1 = u1;
    sbIf.issue_rs2     = rs2;
    sbIf.issue_use_rs2 = u2;
    sbIf.issue_wen     = w;
    sbIf.issue_rd      = rd;
    sbIf.wb_valid      = wbv;
    sbIf.wb_rd         = wbrd;
    sbIf.flush         = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueWrite(input logic [4:0] rd);
    applyStimulus(1, 0, 0, 0, 0, 1, rd, 0, 0, 0);
  endtask

  task automatic writeBack(input logic [4:0] rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rd, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    // Reset: ready is high, the accept in the reset cycle is dropped.
    issueWrite(5);
    checkOutput("ready_in_reset", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("reset_busy", sbIf.busy_mask, 32'h0);
    checkOutput("reset_inflight", 32'(sbIf.inflight), 32'h0);
    checkOutput("reset_err", 32'(sbIf.err), 32'h0);
    rst = 1'b0;
    idle();
    step();
    checkOutput("reset_accept_dropped", sbIf.busy_mask, 32'h0);

    // RAW on x5 until its writeback cycle.
    issueWrite(5);
    checkOutput("x5_issue_ready", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("x5_busy", sbIf.busy_mask, 32'h0000_0020);
    checkOutput("x5_inflight", 32'(sbIf.inflight), 32'h1);
    applyStimulus(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
    checkOutput("raw_x5_stall", 32'(sbIf.issue_ready), 32'h0);
    step();
    checkOutput("raw_stall_busy", sbIf.busy_mask, 32'h0000_0020);
    applyStimulus(1, 5, 1, 0, 0, 1, 6, 1, 5, 0);
    checkOutput("raw_x5_wb_bypass", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("x5_retired_x6_busy", sbIf.busy_mask, 32'h0000_0040);
    checkOutput("x5x6_inflight", 32'(sbIf.inflight), 32'h1);
    writeBack(6);
    step();
    checkOutput("x6_retired", sbIf.busy_mask, 32'h0);

    // Per-register saturation on x7 (max 3 outstanding).
    for (int i = 0; i < 3; i++) begin
      issueWrite(7);
      step();
    end
    checkOutput("x7_inflight3", 32'(sbIf.inflight), 32'h3);
    issueWrite(7);
    checkOutput("x7_full_stall", 32'(sbIf.issue_ready), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    checkOutput("x7_full_wb_stall", 32'(sbIf.issue_ready), 32'h0);
    step();
    checkOutput("x7_after_wb_inflight", 32'(sbIf.inflight), 32'h2);
    issueWrite(7);
    checkOutput("x7_room_ready", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("x7_refilled", 32'(sbIf.inflight), 32'h3);
    for (int i = 0; i < 3; i++) begin
      writeBack(7);
      step();
    end
    checkOutput("x7_drained_busy", sbIf.busy_mask, 32'h0);
    checkOutput("x7_drained_inflight", 32'(sbIf.inflight), 32'h0);

    // Accept and retire x3 in one cycle: count stays 1.
    issueWrite(3);
    step();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
    checkOutput("x3_same_cycle_ready", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("x3_still_busy", sbIf.busy_mask, 32'h0000_0008);
    checkOutput("x3_inflight", 32'(sbIf.inflight), 32'h1);
    writeBack(3);
    step();
    checkOutput("x3_retired", sbIf.busy_mask, 32'h0);

    // Flush beats a simultaneous issue of x4.
    issueWrite(1);
    step();
    issueWrite(2);
    step();
    issueWrite(9);
    step();
    checkOutput("pre_flush_busy", sbIf.busy_mask, 32'h0000_0206);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    checkOutput("flush_blocks_ready", 32'(sbIf.issue_ready), 32'h0);
    step();
    checkOutput("flush_busy", sbIf.busy_mask, 32'h0);
    checkOutput("flush_inflight", 32'(sbIf.inflight), 32'h0);
    applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x4_not_tracked", 32'(sbIf.issue_ready), 32'h1);

    // Total in-flight saturation at 15 stalls writers only.
    for (int r = 1; r <= 15; r++) begin
      issueWrite(5'(r));
      step();
    end
    checkOutput("inflight_sat", 32'(sbIf.inflight), 32'hF);
    issueWrite(16);
    checkOutput("inflight_full_stall", 32'(sbIf.issue_ready), 32'h0);
    applyStimulus(1, 20, 1, 21, 1, 0, 0, 0, 0, 0);
    checkOutput("inflight_full_nowrite_ready", 32'(sbIf.issue_ready), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    checkOutput("sat_flush_busy", sbIf.busy_mask, 32'h0);

    // Error detection and x0 handling.
    writeBack(0);
    step();
    checkOutput("wb_x0_no_err", 32'(sbIf.err), 32'h0);
    writeBack(12);
    step();
    checkOutput("wb_x12_err", 32'(sbIf.err), 32'h1);
    checkOutput("wb_x12_inflight", 32'(sbIf.inflight), 32'h0);
    idle();
    step();
    checkOutput("err_sticky", 32'(sbIf.err), 32'h1);
    applyStimulus(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("x0_ready", 32'(sbIf.issue_ready), 32'h1);
    step();
    checkOutput("x0_busy", sbIf.busy_mask, 32'h0);
    checkOutput("x0_inflight", 32'(sbIf.inflight), 32'h0);

    // Reset mid-operation overrides accept and retire.
    issueWrite(10);
    step();
    checkOutput("x10_busy", sbIf.busy_mask, 32'h0000_0400);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 1, 11, 1, 10, 0);
    step();
    checkOutput("midrst_busy", sbIf.busy_mask, 32'h0);
    checkOutput("midrst_inflight", 32'(sbIf.inflight), 32'h0);
    checkOutput("midrst_err", 32'(sbIf.err), 32'h0);
    rst = 1'b0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
